// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl_pkg
//  Description : Shared definitions for the shift-sequence controller.
//                Holds the shift-register mode encoding driven on sel, the
//                controller state enum, and a helper that maps a shift
//                direction onto its sel code.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_ctrl_pkg;

    // Shift-register mode encoding on sel
    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_SHR  = 2'd1;
    localparam logic [1:0] SEL_SHL  = 2'd2;
    localparam logic [1:0] SEL_LOAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // dir = 0 shifts right, dir = 1 shifts left
    function automatic logic [1:0] shift_sel(input logic dir);
        return dir ? SEL_SHL : SEL_SHR;
    endfunction

endpackage : shift_seq_ctrl_pkg
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Command-driven sequencer for an external 4-bit universal
//                shift register. A command is loaded in parallel, shifted
//                count times in the chosen direction with a fill bit, then
//                the register contents are captured and reported.
//
//  Ports
//    clk            system clock, rising edge
//    clr            asynchronous active-low reset
//    cmd_valid      command offered
//    cmd_ready      controller idle and able to accept
//    cmd_data       parallel word to load
//    cmd_dir        0 = shift right, 1 = shift left
//    cmd_count      number of shift cycles (0 allowed)
//    cmd_fill       serial bit injected on every shift
//    abort          cancels a command in LOAD or SHIFT
//    sel            shift-register mode (hold / shr / shl / load)
//    par_out        parallel word to the shift register
//    serialright    serial input used on right shifts
//    serialleft     serial input used on left shifts
//    q              shift-register contents
//    result         q captured at the end of the command
//    result_valid   one-cycle pulse qualifying result
//    busy           high whenever not idle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             abort,
    output logic [1:0]       sel,
    output logic [3:0]       par_out,
    output logic             serialright,
    output logic             serialleft,
    input  logic [3:0]       q,
    output logic [3:0]       result,
    output logic             result_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             dir_lat;
    logic             fill_lat;
    logic [CNT_W-1:0] count_lat;
    // Counts remaining shifts; the last shift is issued while it reads 1,
    // so it never decrements past 1 and a full-scale count cannot wrap.
    logic [CNT_W-1:0] shift_cnt;

    // All outputs are registered and updated together with the state, so
    // each output always describes the state the controller is in now.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= ST_IDLE;
            dir_lat      <= 1'b0;
            fill_lat     <= 1'b0;
            count_lat    <= '0;
            shift_cnt    <= '0;
            sel          <= SEL_HOLD;
            par_out      <= 4'd0;
            serialright  <= 1'b0;
            serialleft   <= 1'b0;
            result       <= 4'd0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            // Held low through reset; rises on the first clock afterwards.
            cmd_ready    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sel         <= SEL_HOLD;
                    serialright <= 1'b0;
                    serialleft  <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        dir_lat   <= cmd_dir;
                        fill_lat  <= cmd_fill;
                        count_lat <= cmd_count;
                        par_out   <= cmd_data;
                        sel       <= SEL_LOAD;
                        state     <= ST_LOAD;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end else begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        sel       <= SEL_HOLD;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (count_lat != '0) begin
                        state       <= ST_SHIFT;
                        shift_cnt   <= count_lat;
                        sel         <= shift_sel(dir_lat);
                        serialright <= ~dir_lat & fill_lat;
                        serialleft  <= dir_lat & fill_lat;
                    end else begin
                        state <= ST_CAPTURE;
                        sel   <= SEL_HOLD;
                    end
                end

                ST_SHIFT: begin
                    if (abort) begin
                        state       <= ST_IDLE;
                        sel         <= SEL_HOLD;
                        serialright <= 1'b0;
                        serialleft  <= 1'b0;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                    end else if (shift_cnt == CNT_ONE) begin
                        state       <= ST_CAPTURE;
                        sel         <= SEL_HOLD;
                        serialright <= 1'b0;
                        serialleft  <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt - CNT_ONE;
                    end
                end

                ST_CAPTURE: begin
                    // The register holds during this cycle, so q already
                    // reflects the final shift.
                    result       <= q;
                    result_valid <= 1'b1;
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    cmd_ready    <= 1'b1;
                end

                default: begin
                    state       <= ST_IDLE;
                    sel         <= SEL_HOLD;
                    serialright <= 1'b0;
                    serialleft  <= 1'b0;
                    busy        <= 1'b0;
                    cmd_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule : shift_seq_ctrl
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl with a 4-bit
//                universal shift register attached to its outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic       abort;
    logic [1:0] sel;
    logic [3:0] par_out;
    logic       serialright;
    logic       serialleft;
    logic [3:0] q;
    logic [3:0] result;
    logic       result_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.CNT_W(3)) dut (
        .clk          (clk),
        .clr          (clr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_fill     (cmd_fill),
        .abort        (abort),
        .sel          (sel),
        .par_out      (par_out),
        .serialright  (serialright),
        .serialleft   (serialleft),
        .q            (q),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    // External universal shift register: right shift enters at the MSB,
    // left shift enters at the LSB.
    always @(posedge clk) begin
        case (sel)
            2'd1:    q <= {serialright, q[3:1]};
            2'd2:    q <= {q[2:0], serialleft};
            2'd3:    q <= par_out;
            default: q <= q;
        endcase
    end

    // Word after c shifts of d in direction dr with fill f
    function automatic logic [3:0] ref_result(input logic [3:0] d, input logic dr,
                                              input int c, input logic f);
        logic [3:0] v;
        v = d;
        for (int i = 0; i < c; i++)
            v = dr ? {v[2:0], f} : {f, v[3:1]};
        return v;
    endfunction

    // Issues one command and checks every cycle up to the result pulse.
    // ab: cycle in which abort is held (0 = acceptance cycle, k = k-th
    // cycle after acceptance), -1 for none.
    task automatic do_cmd(input string nm, input logic [3:0] d, input logic dr,
                          input int c, input logic f, input int ab,
                          input logic [3:0] exp_res);
        int         w;
        logic       aborted;
        logic [1:0] es;
        logic       esr, esl, ebusy, erv;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s wait_ready: cmd_ready=%b after %0d cycles, need 1", nm, cmd_ready, w);
            bad++;
            return;
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dr;
        cmd_count = 3'(c);
        cmd_fill  = f;
        abort     = (ab == 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_data  = 4'($urandom);
        aborted   = 1'b0;
        for (int k = 1; k <= c + 3; k++) begin
            if (aborted) begin
                total++;
                if (sel !== 2'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 || result_valid !== 1'b0) begin
                    $display("FAIL %s after_abort: sel=%0d busy=%b ready=%b rv=%b, need 0 0 1 0",
                             nm, sel, busy, cmd_ready, result_valid);
                    bad++;
                end
                break;
            end
            es    = (k == 1) ? 2'd3 : (k <= c + 1) ? (dr ? 2'd2 : 2'd1) : 2'd0;
            esr   = (k >= 2 && k <= c + 1 && !dr) ? f : 1'b0;
            esl   = (k >= 2 && k <= c + 1 &&  dr) ? f : 1'b0;
            ebusy = (k <= c + 2);
            erv   = (k == c + 3);
            total++;
            if (sel !== es) begin
                $display("FAIL %s sel k=%0d: got %0d need %0d", nm, k, sel, es);
                bad++;
            end
            total++;
            if (serialright !== esr || serialleft !== esl) begin
                $display("FAIL %s serial k=%0d: got r=%b l=%b need r=%b l=%b",
                         nm, k, serialright, serialleft, esr, esl);
                bad++;
            end
            total++;
            if (busy !== ebusy || cmd_ready !== !ebusy) begin
                $display("FAIL %s busy k=%0d: got busy=%b ready=%b need busy=%b",
                         nm, k, busy, cmd_ready, ebusy);
                bad++;
            end
            total++;
            if (result_valid !== erv) begin
                $display("FAIL %s result_valid k=%0d: got %b need %b", nm, k, result_valid, erv);
                bad++;
            end
            if (k == 1) begin
                total++;
                if (par_out !== d) begin
                    $display("FAIL %s par_out: got %b need %b", nm, par_out, d);
                    bad++;
                end
            end
            if (erv) begin
                total++;
                if (result !== exp_res) begin
                    $display("FAIL %s result: got %b need %b", nm, result, exp_res);
                    bad++;
                end
            end
            if (ab == k && k <= c + 1) aborted = 1'b1;
            abort = (ab == k);
            @(negedge clk);
            abort = 1'b0;
        end
        // No result may follow an abort, and a result pulse lasts one cycle.
        for (int i = 0; i < (aborted ? 4 : 1); i++) begin
            if (aborted) @(negedge clk);
            total++;
            if (result_valid !== 1'b0) begin
                $display("FAIL %s extra_result_valid: got %b need 0", nm, result_valid);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        cmd_valid = 1'b0; cmd_data = 4'd0; cmd_dir = 1'b0;
        cmd_count = 3'd0; cmd_fill = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (sel !== 2'd0 || par_out !== 4'd0 || serialright !== 1'b0 || serialleft !== 1'b0 ||
            result !== 4'd0 || result_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            $display("FAIL reset_state: sel=%0d par=%b sr=%b sl=%b res=%b rv=%b busy=%b ready=%b, need all 0",
                     sel, par_out, serialright, serialleft, result, result_valid, busy, cmd_ready);
            bad++;
        end
        clr = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL reset_release_ready: got %b need 0 before first clock", cmd_ready);
            bad++;
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_first_clock: ready=%b busy=%b need 1 0", cmd_ready, busy);
            bad++;
        end
    endtask

    task automatic test_directed();
        do_cmd("right_c2",   4'b0110, 1'b0, 2, 1'b1, -1, 4'b1101);
        do_cmd("left_c3",    4'b0110, 1'b1, 3, 1'b1, -1, 4'b0111);
        do_cmd("count0",     4'b1010, 1'b0, 0, 1'b1, -1, 4'b1010);
        do_cmd("max_count",  4'b0000, 1'b0, 7, 1'b1, -1, 4'b1111);
        do_cmd("max_left",   4'b1011, 1'b1, 7, 1'b0, -1, 4'b0000);
    endtask

    task automatic test_abort();
        // Cycle 3 after acceptance is the second SHIFT cycle
        do_cmd("abort_shift2", 4'b1001, 1'b0, 7, 1'b1, 3, 4'b0000);
        do_cmd("abort_load",   4'b0101, 1'b1, 4, 1'b0, 1, 4'b0000);
        // Abort in IDLE (acceptance cycle) and in CAPTURE is ignored
        do_cmd("abort_idle",    4'b0011, 1'b1, 2, 1'b0, 0, 4'b1100);
        do_cmd("abort_capture", 4'b1000, 1'b0, 4, 1'b0, 6, 4'b0000);
        do_cmd("after_abort",   4'b0001, 1'b1, 1, 1'b1, -1, 4'b0011);
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_data = 4'b1110; cmd_dir = 1'b0;
        cmd_count = 3'd7; cmd_fill = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sel !== 2'd1 || busy !== 1'b1) begin
            $display("FAIL reset_mid_shifting: sel=%0d busy=%b need 1 1", sel, busy);
            bad++;
        end
        @(posedge clk);
        #2 clr = 1'b0;
        #1;
        total++;
        if (sel !== 2'd0 || par_out !== 4'd0 || serialright !== 1'b0 || serialleft !== 1'b0 ||
            result !== 4'd0 || result_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            $display("FAIL reset_mid_async: sel=%0d par=%b sr=%b sl=%b res=%b rv=%b busy=%b ready=%b, need all 0",
                     sel, par_out, serialright, serialleft, result, result_valid, busy, cmd_ready);
            bad++;
        end
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if (result_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                $display("FAIL reset_mid_discard cyc=%0d: rv=%b ready=%b need 0 1", i, result_valid, cmd_ready);
                bad++;
            end
        end
        do_cmd("post_reset", 4'b0110, 1'b0, 2, 1'b1, -1, 4'b1101);
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic       dr, f;
        int         c, ab;
        for (int n = 0; n < 24; n++) begin
            d  = 4'($urandom);
            dr = 1'($urandom);
            f  = 1'($urandom);
            c  = int'($urandom_range(0, 7));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c + 2)) : -1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd("random", d, dr, c, f, ab, ref_result(d, dr, c, f));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_q[$];
        logic [3:0] e;
        int         accepts, results, cyc, last;
        logic       just_accepted;
        accepts = 0; results = 0; cyc = 0; last = 0; just_accepted = 1'b0;
        cmd_valid = 1'b1;
        cmd_count = 3'd1;
        cmd_data  = 4'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_fill  = 1'($urandom);
        forever begin
            if (result_valid === 1'b1) begin
                results++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_spurious_result: got %b with none expected", result);
                    bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e) begin
                        $display("FAIL b2b_result: got %b need %b", result, e);
                        bad++;
                    end
                end
            end
            if (just_accepted) begin
                // New fields appear while busy and must not be taken
                cmd_data = 4'($urandom);
                cmd_dir  = 1'($urandom);
                cmd_fill = 1'($urandom);
                just_accepted = 1'b0;
            end
            if (cmd_ready === 1'b1) begin
                if (accepts > 0) begin
                    total++;
                    if (cyc - last != 4) begin
                        $display("FAIL b2b_spacing: got %0d cycles need 4", cyc - last);
                        bad++;
                    end
                end
                exp_q.push_back(ref_result(cmd_data, cmd_dir, 1, cmd_fill));
                last = cyc;
                accepts++;
                just_accepted = 1'b1;
            end
            if (accepts == 8 || cyc >= 80) break;
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (result_valid === 1'b1) begin
                results++;
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_spurious_result: got %b with none expected", result);
                    bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (result !== e) begin
                        $display("FAIL b2b_result: got %b need %b", result, e);
                        bad++;
                    end
                end
            end
        end
        total++;
        if (accepts != 8 || results != 8 || exp_q.size() != 0) begin
            $display("FAIL b2b_counts: accepts=%0d results=%0d pending=%0d need 8 8 0",
                     accepts, results, exp_q.size());
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_seq_ctrl
`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 3: width of the shift-count field.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller can accept a command.
REQ-006 cmd_data  input  4  parallel word to load.
REQ-007 cmd_dir  input  1  0 = shift right, 1 = shift left.
REQ-008 cmd_count  input  CNT_W  number of shift cycles (0 allowed).
REQ-009 cmd_fill  input  1  serial bit injected on every shift.
REQ-010 abort  input  1  synchronous cancel of the current command.
REQ-011 sel  output  2  shift-register mode: 0 hold, 1 shift right, 2 shift left, 3 parallel load.
REQ-012 par_out  output  4  parallel word driven to the shift register.
REQ-013 serialright / serialleft  output  1 each  serial bits to the shift register.
REQ-014 q  input  4  shift-register contents, consumed for the result.
REQ-015 result  output  4  captured q at command end.
REQ-016 result_valid  output  1  single-cycle pulse qualifying result.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT, CAPTURE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready, registering data, dir, count, fill.
REQ-020 IDLE -> LOAD on acceptance; LOAD lasts exactly one cycle with sel=3, par_out=latched data.
REQ-021 LOAD -> SHIFT if count != 0, else LOAD -> CAPTURE.
REQ-022 In SHIFT, sel SHALL be 1 (dir=0) or 2 (dir=1) for exactly count cycles, tracked by a down-counter loaded with count.
REQ-023 During SHIFT, serialright = fill when dir=0, serialleft = fill when dir=1; the unused serial output SHALL be 0.
REQ-024 SHIFT -> CAPTURE when the down-counter reaches 1 and a shift is issued.
REQ-025 CAPTURE lasts one cycle with sel=0; result SHALL register q at its end and result_valid SHALL pulse the following cycle; state returns to IDLE.
REQ-026 Total latency acceptance-to-result_valid SHALL be count+3 cycles.
REQ-027 In IDLE and CAPTURE, sel=0 and both serial outputs 0; par_out SHALL hold its last value.
REQ-028 abort in LOAD or SHIFT SHALL force IDLE next cycle with sel=0, no result_valid; abort in IDLE or CAPTURE SHALL be ignored.
REQ-029 cmd_valid while busy SHALL be ignored (not queued).
REQ-030 Maximum count (2**CNT_W-1) SHALL be supported without counter wrap.

Reset
REQ-031 Asserting clr SHALL immediately force IDLE, sel=0, par_out=0, serial outputs 0, result=0, result_valid=0, busy=0, cmd_ready=0 while clr low.
REQ-032 cmd_ready SHALL rise the first clock after clr deasserts; reset mid-command SHALL discard it with no result_valid.

Structure
REQ-033 A shared package SHALL hold the sel encoding constants (HOLD, SHR, SHL, LOAD) and the FSM state enum.
REQ-034 No sub-module; the shift register itself is instantiated only in the bench alongside this block.

Verification
REQ-035 data=0110, dir=0, count=2, fill=1 -> sel 3,1,1,0; result=1101 with result_valid 5 cycles after acceptance.
REQ-036 data=0110, dir=1, count=3, fill=1 -> sel 3,2,2,2,0; result=0111 after 6 cycles.
REQ-037 count=0, data=1010 -> sel 3 then 0; result=1010 after 3 cycles; no SHIFT cycle.
REQ-038 abort asserted on 2nd SHIFT cycle of count=7 command -> sel=0 next cycle, cmd_ready=1, no result_valid.
REQ-039 clr pulsed low mid-SHIFT -> all outputs 0 asynchronously; new command after release completes normally.
REQ-040 cmd_valid held high continuously with count=1 -> back-to-back commands accepted every 4 cycles, none dropped or duplicated.
